branch_redirect_ctrl: RTL and testbench



---
 rtl/branch_redirect_ctrl_if.sv | 42 ++++
 rtl/branch_redirect_ctrl.sv | 122 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_if.sv
// Bundle between the branch write-back arbiter, the issue stage and the warp scheduler.
// The slave modport is the redirect controller's own view of this bundle.
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

interface branch_redirect_ctrl_if #(
  parameter int DEPTH_WARP = `DEPTH_WARP
);
  localparam int NUM_WARP = 2 ** DEPTH_WARP;

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DEPTH_WARP-1:0] in_wid_i;
  logic                  in_jump_i;
  logic [31:0]           in_new_pc_i;
  logic                  issue_br_valid_i;
  logic [DEPTH_WARP-1:0] issue_br_wid_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DEPTH_WARP-1:0] out_wid_o;
  logic                  out_jump_o;
  logic [31:0]           out_new_pc_o;
  logic                  flush_valid_o;
  logic [DEPTH_WARP-1:0] flush_wid_o;
  logic [NUM_WARP-1:0]   br_pending_o;
  logic                  err_o;

  modport master (
    output in_valid_i, in_wid_i, in_jump_i, in_new_pc_i,
    output issue_br_valid_i, issue_br_wid_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_wid_o, out_jump_o, out_new_pc_o,
    input  flush_valid_o, flush_wid_o, br_pending_o, err_o
  );

  modport slave (
    input  in_valid_i, in_wid_i, in_jump_i, in_new_pc_i,
    input  issue_br_valid_i, issue_br_wid_i, out_ready_i,
    output in_ready_o, out_valid_o, out_wid_o, out_jump_o, out_new_pc_o,
    output flush_valid_o, flush_wid_o, br_pending_o, err_o
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Buffers resolved branches, forwards them to the scheduler as PC redirects,
// pulses an instruction-buffer flush on taken branches, and tracks per-warp branch stalls.
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

module branch_redirect_ctrl #(
  parameter int DEPTH_WARP = `DEPTH_WARP,
  parameter int BUF_DEPTH  = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_redirect_ctrl_if.slave bus
);
  localparam int NUM_WARP = 2 ** DEPTH_WARP;
  localparam int PW       = $clog2(BUF_DEPTH);
  localparam int CW       = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  typedef struct packed {
    logic [DEPTH_WARP-1:0] wid;
    logic                  jump;
    logic [31:0]           pc;
  } rec_t;

  rec_t                  mem_q [BUF_DEPTH];
  rec_t                  mem_d [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  flush_valid_q, flush_valid_d;
  logic [DEPTH_WARP-1:0] flush_wid_q, flush_wid_d;
  logic [NUM_WARP-1:0]   pend_q, pend_d;
  logic                  err_q, err_d;

  logic in_ready, out_valid, push, pop;
  rec_t head;

  // Ready looks only at the registered count, so a pop never opens the door in the same cycle.
  always_comb begin
    in_ready  = (count_q != FULL);
    out_valid = (count_q != '0);
    head      = mem_q[rd_ptr_q];
    push      = bus.in_valid_i & in_ready;
    pop       = out_valid & bus.out_ready_i;
  end

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    flush_valid_d = 1'b0;
    flush_wid_d   = flush_wid_q;
    pend_d        = pend_q;
    err_d         = err_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{wid: bus.in_wid_i, jump: bus.in_jump_i, pc: bus.in_new_pc_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if (bus.in_jump_i) begin
        flush_valid_d = 1'b1;
        flush_wid_d   = bus.in_wid_i;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear before set so a same-cycle release and re-issue of one warp leaves it stalled.
    if (pop) begin
      pend_d[head.wid] = 1'b0;
      if (!pend_q[head.wid]) err_d = 1'b1;
    end
    if (bus.issue_br_valid_i) begin
      pend_d[bus.issue_br_wid_i] = 1'b1;
      if (pend_q[bus.issue_br_wid_i] && !(pop && (head.wid == bus.issue_br_wid_i))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      flush_valid_q <= 1'b0;
      flush_wid_q   <= '0;
      pend_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      flush_valid_q <= flush_valid_d;
      flush_wid_q   <= flush_wid_d;
      pend_q        <= pend_d;
      err_q         <= err_d;
    end
  end

  // Storage needs no reset; outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = out_valid;
  assign bus.out_wid_o     = out_valid ? head.wid  : '0;
  assign bus.out_jump_o    = out_valid ? head.jump : 1'b0;
  assign bus.out_new_pc_o  = out_valid ? head.pc   : 32'h0;
  assign bus.flush_valid_o = flush_valid_q;
  assign bus.flush_wid_o   = flush_wid_q;
  assign bus.br_pending_o  = pend_q;
  assign bus.err_o         = err_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: a table of hand-derived vectors,
// a few directed reset/error sequences, and a scoreboarded streaming run.
module tb_branch_redirect_ctrl;
  localparam int DW = 3;
  localparam int NW = 2 ** DW;

  logic clk;
  logic rst;

  branch_redirect_ctrl_if #(.DEPTH_WARP(DW)) bus ();

  branch_redirect_ctrl #(.DEPTH_WARP(DW), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          iv;
    logic [DW-1:0] wid;
    logic          jmp;
    logic [31:0]   pc;
    logic          isv;
    logic [DW-1:0] iwid;
    logic          ordy;
  } stim_t;

  typedef struct packed {
    logic          ov;
    logic [DW-1:0] owid;
    logic          ojmp;
    logic [31:0]   opc;
    logic          ir;
    logic          fv;
    logic [DW-1:0] fwid;
    logic [NW-1:0] pend;
    logic          err;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] wid;
    logic [31:0]   pc;
  } sb_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t tbl [18];
  sb_t  sb_q [$];

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] wid, input logic jmp,
                              input logic [31:0] pc, input logic isv, input logic [DW-1:0] iwid,
                              input logic ordy, input logic ov, input logic [DW-1:0] owid,
                              input logic ojmp, input logic [31:0] opc, input logic ir,
                              input logic fv, input logic [DW-1:0] fwid, input logic [NW-1:0] pend,
                              input logic err);
    vec_t v;
    v.s = '{iv: iv, wid: wid, jmp: jmp, pc: pc, isv: isv, iwid: iwid, ordy: ordy};
    v.e = '{ov: ov, owid: owid, ojmp: ojmp, opc: opc, ir: ir, fv: fv, fwid: fwid,
            pend: pend, err: err};
    return v;
  endfunction

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    cmp(name, "out_valid",   32'(bus.out_valid_o),   32'(e.ov));
    cmp(name, "out_wid",     32'(bus.out_wid_o),     32'(e.owid));
    cmp(name, "out_jump",    32'(bus.out_jump_o),    32'(e.ojmp));
    cmp(name, "out_new_pc",  bus.out_new_pc_o,       e.opc);
    cmp(name, "in_ready",    32'(bus.in_ready_o),    32'(e.ir));
    cmp(name, "flush_valid", 32'(bus.flush_valid_o), 32'(e.fv));
    cmp(name, "flush_wid",   32'(bus.flush_wid_o),   32'(e.fwid));
    cmp(name, "br_pending",  32'(bus.br_pending_o),  32'(e.pend));
    cmp(name, "err",         32'(bus.err_o),         32'(e.err));
  endtask

  task automatic drive(input stim_t s);
    bus.in_valid_i       = s.iv;
    bus.in_wid_i         = s.wid;
    bus.in_jump_i        = s.jmp;
    bus.in_new_pc_i      = s.pc;
    bus.issue_br_valid_i = s.isv;
    bus.issue_br_wid_i   = s.iwid;
    bus.out_ready_i      = s.ordy;
  endtask

  task automatic applyStimulus(input stim_t s);
    drive(s);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    drive('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic runVec(input string name, input vec_t v);
    applyStimulus(v.s);
    checkOutput(name, v.e);
  endtask

  initial begin
    exp_t  rst_exp;
    logic  ordy, can_push, do_pop;
    int    m_cnt, seq;
    logic [DW-1:0] w;

    // iv wid jmp pc isv iwid ordy | ov owid ojmp opc ir fv fwid pend err
    tbl[0]  = mk(0,0,0,32'h0,        0,0,0, 0,0,0,32'h0,        1, 0,0, 8'h00, 0);
    tbl[1]  = mk(0,0,0,32'h0,        1,3,0, 0,0,0,32'h0,        1, 0,0, 8'h08, 0);
    tbl[2]  = mk(1,3,1,32'h8000_0040,0,0,0, 1,3,1,32'h8000_0040,1, 1,3, 8'h08, 0);
    tbl[3]  = mk(0,0,0,32'h0,        0,0,0, 1,3,1,32'h8000_0040,1, 0,3, 8'h08, 0);
    tbl[4]  = mk(0,0,0,32'h0,        0,0,1, 0,0,0,32'h0,        1, 0,3, 8'h00, 0);
    tbl[5]  = mk(0,0,0,32'h0,        1,1,0, 0,0,0,32'h0,        1, 0,3, 8'h02, 0);
    tbl[6]  = mk(1,1,0,32'h0000_1000,0,0,0, 1,1,0,32'h0000_1000,1, 0,3, 8'h02, 0);
    tbl[7]  = mk(0,0,0,32'h0,        0,0,1, 0,0,0,32'h0,        1, 0,3, 8'h00, 0);
    tbl[8]  = mk(1,4,1,32'h0000_0100,1,4,0, 1,4,1,32'h0000_0100,1, 1,4, 8'h10, 0);
    tbl[9]  = mk(1,6,0,32'h0000_0200,1,6,0, 1,4,1,32'h0000_0100,0, 0,4, 8'h50, 0);
    tbl[10] = mk(1,7,1,32'h0000_0300,1,7,0, 1,4,1,32'h0000_0100,0, 0,4, 8'hD0, 0);
    tbl[11] = mk(1,7,1,32'h0000_0300,0,0,1, 1,6,0,32'h0000_0200,1, 0,4, 8'hC0, 0);
    tbl[12] = mk(1,7,1,32'h0000_0300,0,0,0, 1,6,0,32'h0000_0200,0, 1,7, 8'hC0, 0);
    tbl[13] = mk(0,0,0,32'h0,        0,0,1, 1,7,1,32'h0000_0300,1, 0,7, 8'h80, 0);
    tbl[14] = mk(0,0,0,32'h0,        0,0,1, 0,0,0,32'h0,        1, 0,7, 8'h00, 0);
    tbl[15] = mk(1,5,0,32'h0000_0500,0,0,0, 1,5,0,32'h0000_0500,1, 0,7, 8'h00, 0);
    tbl[16] = mk(0,0,0,32'h0,        0,0,1, 0,0,0,32'h0,        1, 0,7, 8'h00, 1);
    tbl[17] = mk(0,0,0,32'h0,        0,0,0, 0,0,0,32'h0,        1, 0,7, 8'h00, 1);

    rst_exp = '{ov: 0, owid: 0, ojmp: 0, opc: 32'h0, ir: 1, fv: 0, fwid: 0, pend: '0, err: 0};

    rst = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    doReset();
    checkOutput("reset", rst_exp);

    for (int i = 0; i < 18; i++) begin
      runVec($sformatf("row%0d", i), tbl[i]);
    end

    // Reset with a record queued and err set must discard everything.
    runVec("pre_reset", mk(1,2,1,32'h0000_0600,1,2,0, 1,2,1,32'h0000_0600,1, 1,2, 8'h04, 1));
    doReset();
    checkOutput("mid_reset", rst_exp);

    runVec("sc_issue2",  mk(0,0,0,32'h0,        1,2,0, 0,0,0,32'h0,        1, 0,0, 8'h04, 0));
    runVec("sc_enq2",    mk(1,2,1,32'h0000_0600,0,0,0, 1,2,1,32'h0000_0600,1, 1,2, 8'h04, 0));
    runVec("sc_setclr2", mk(0,0,0,32'h0,        1,2,1, 0,0,0,32'h0,        1, 0,2, 8'h04, 0));
    runVec("dup_issue2", mk(0,0,0,32'h0,        1,2,0, 0,0,0,32'h0,        1, 0,2, 8'h04, 1));

    // Streaming run: fill to full with the scheduler stalled, then push and pop every cycle.
    doReset();
    m_cnt = 0;
    seq   = 0;
    for (int k = 0; k < 14; k++) begin
      ordy     = (k >= 2);
      can_push = (m_cnt < 2);
      do_pop   = ordy && (m_cnt > 0);
      cmp($sformatf("stream%0d", k), "in_ready", 32'(bus.in_ready_o), 32'(can_push));
      if (do_pop) begin
        cmp($sformatf("stream%0d", k), "out_valid",  32'(bus.out_valid_o), 32'd1);
        cmp($sformatf("stream%0d", k), "out_wid",    32'(bus.out_wid_o),   32'(sb_q[0].wid));
        cmp($sformatf("stream%0d", k), "out_new_pc", bus.out_new_pc_o,     sb_q[0].pc);
        void'(sb_q.pop_front());
      end
      w = DW'(seq % NW);
      drive('{iv: 1'b1, wid: w, jmp: 1'b0, pc: 32'h4000_0000 + 32'(seq * 4),
              isv: can_push, iwid: w, ordy: ordy});
      if (can_push) begin
        sb_q.push_back('{wid: w, pc: 32'h4000_0000 + 32'(seq * 4)});
        seq++;
      end
      m_cnt = m_cnt + int'(can_push) - int'(do_pop);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      if (m_cnt > 0) begin
        cmp($sformatf("drain%0d", k), "out_valid",  32'(bus.out_valid_o), 32'd1);
        cmp($sformatf("drain%0d", k), "out_wid",    32'(bus.out_wid_o),   32'(sb_q[0].wid));
        cmp($sformatf("drain%0d", k), "out_new_pc", bus.out_new_pc_o,     sb_q[0].pc);
        void'(sb_q.pop_front());
        m_cnt--;
      end
      drive('{iv: 1'b0, wid: '0, jmp: 1'b0, pc: 32'h0, isv: 1'b0, iwid: '0, ordy: 1'b1});
      @(posedge clk);
      #1;
    end
    cmp("stream_end", "out_valid",  32'(bus.out_valid_o),  32'd0);
    cmp("stream_end", "br_pending", 32'(bus.br_pending_o), 32'd0);
    cmp("stream_end", "err",        32'(bus.err_o),        32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
